// File: rtl/blink_monitor_if.sv
// blink_monitor_if: sample tick, monitored line and measured-period outputs of the blink monitor.
interface blink_monitor_if #(parameter int CNT_W = 8);
  logic             en;
  logic             in;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             blinking;
  logic             level;
  modport master (output en, in, input period, period_valid, blinking, level);
  modport slave  (input en, in, output period, period_valid, blinking, level);
endinterface

// File: rtl/blink_monitor.sv
// blink_monitor: measures en ticks between toggles of a synchronized line and flags active blinking.
module blink_monitor #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 100
) (
  input logic            clk,
  input logic            reset,
  blink_monitor_if.slave bus
);
  localparam logic [1:0] INIT = 2'd0, IDLE = 2'd1, ARMED = 2'd2, BLINKING = 2'd3;
  localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT);
  logic             s1, s;
  logic [1:0]       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic             toggle, timeout, report;
  always_comb begin
    toggle   = state != INIT && s != bus.level;
    cnt_inc  = cnt == TMAX ? cnt : cnt + 1'b1;
    timeout  = !toggle && cnt_inc == TMAX;
    report   = toggle && (state == ARMED || state == BLINKING);
    // an edge on the tick the counter would expire wins over the timeout
    state_nx = state == INIT ? IDLE :
               toggle        ? (state == IDLE ? ARMED : BLINKING) :
               timeout       ? IDLE : state;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1               <= 1'b0;
      s                <= 1'b0;
      state            <= INIT;
      cnt              <= '0;
      bus.period       <= '0;
      bus.period_valid <= 1'b0;
      bus.blinking     <= 1'b0;
      bus.level        <= 1'b0;
    end else begin
      s1               <= bus.in;
      s                <= s1;
      bus.period_valid <= bus.en && report;
      if (bus.en) begin
        bus.level    <= s;
        state        <= state_nx;
        cnt          <= state == INIT ? cnt : toggle ? '0 : cnt_inc;
        bus.blinking <= state_nx == BLINKING;
        if (report) bus.period <= cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_blink_monitor.sv
// tb_blink_monitor: random and directed stimulus scored against a tick-history model of the monitor.
module tb_blink_monitor;
  localparam int CNT_W = 8, TIMEOUT = 100;
  logic clk = 1'b0, reset = 1'b0;
  int   chk_cnt = 0, pass_cnt = 0;
  int   exp_q[$];
  int   tick, last_edge, m_period;
  bit   have_level, m_level, last_rep, m_pv, m_blink, p1, p2, cur_in;
  blink_monitor_if #(.CNT_W(CNT_W)) bus ();
  blink_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask
  task automatic model_clear();
    tick = 0; last_edge = -1; m_period = 0; have_level = 0; m_level = 0;
    last_rep = 0; m_pv = 0; m_blink = 0; p1 = 0; p2 = 0;
    exp_q.delete();
  endtask
  // The model thinks in edge timestamps: a gap is reported when the previous edge is known and no more than TIMEOUT ticks old.
  task automatic model_step(input bit e, input bit i);
    bit s_now;
    if (!reset) begin model_clear(); return; end
    s_now = p2; p2 = p1; p1 = i;
    m_pv = 0;
    if (!e) return;
    if (!have_level) begin
      have_level = 1; m_level = s_now; tick = 0;
    end else begin
      tick++;
      if (s_now != m_level) begin
        if (last_edge >= 0 && tick - last_edge <= TIMEOUT) begin
          m_period = tick - last_edge; m_pv = 1; last_rep = 1;
          exp_q.push_back(m_period);
        end else last_rep = 0;
        last_edge = tick;
      end
      m_level = s_now;
    end
    m_blink = last_rep && last_edge >= 0 && tick - last_edge < TIMEOUT;
  endtask
  task automatic step(input bit e, input bit i);
    @(negedge clk);
    bus.en = e; bus.in = i;
    model_step(e, i);
  endtask
  task automatic run_ticks(input int n, input int gap, input int toggle_every);
    for (int k = 1; k <= n; k++) begin
      if (toggle_every > 0 && k % toggle_every == 0) cur_in = ~cur_in;
      for (int g = 1; g < gap; g++) step(1'b0, cur_in);
      step(1'b1, cur_in);
    end
  endtask
  task automatic async_reset();
    @(negedge clk);
    #3 reset = 1'b0;
    model_clear();
    #1;
    chk("rst_period", int'(bus.period), 0);
    chk("rst_period_valid", int'(bus.period_valid), 0);
    chk("rst_blinking", int'(bus.blinking), 0);
    chk("rst_level", int'(bus.level), 0);
    repeat (3) step(1'b0, cur_in);
    @(negedge clk);
    reset = 1'b1;
    bus.en = 1'b0;
    model_step(1'b0, cur_in);
  endtask
  always begin
    @(posedge clk);
    #2;
    chk("level", int'(bus.level), int'(m_level));
    chk("blinking", int'(bus.blinking), int'(m_blink));
    chk("period", int'(bus.period), m_period);
    chk("period_valid", int'(bus.period_valid), int'(m_pv));
    if (bus.period_valid) begin
      if (exp_q.size() == 0) chk("unexpected_pulse", 1, 0);
      else chk("pulse_period", int'(bus.period), exp_q.pop_front());
    end
  end
  initial begin
    bus.en = 1'b0; bus.in = 1'b1; cur_in = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    #1;
    chk("init_period", int'(bus.period), 0);
    chk("init_blinking", int'(bus.blinking), 0);
    chk("init_level", int'(bus.level), 0);
    @(negedge clk);
    reset = 1'b1;
    model_step(1'b0, cur_in);
    repeat (3) step(1'b0, cur_in);
    step(1'b1, cur_in);
    step(1'b0, cur_in);
    chk("init_level_loaded", int'(bus.level), 1);
    for (int k = 0; k < 20; k++) begin cur_in = ~cur_in; step(1'b1, cur_in); end
    run_ticks(40, 4, 5);
    run_ticks(110, 1, 0);
    run_ticks(12, 1, 3);
    run_ticks(TIMEOUT, 1, TIMEOUT);
    run_ticks(6, 1, 3);
    run_ticks(TIMEOUT + 1, 1, TIMEOUT + 1);
    run_ticks(12, 2, 2);
    async_reset();
    run_ticks(12, 1, 3);
    for (int seg = 0; seg < 8; seg++) begin
      int en_mod, tog_mod;
      en_mod  = $urandom_range(1, 3);
      tog_mod = (seg % 3 == 2) ? $urandom_range(60, 160) : $urandom_range(1, 8);
      for (int c = 0; c < 500; c++) begin
        if ($urandom_range(0, tog_mod - 1) == 0) cur_in = ~cur_in;
        step($urandom_range(0, en_mod - 1) == 0, cur_in);
      end
      if (seg == 4) async_reset();
    end
    repeat (4) step(1'b0, cur_in);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
